// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD write arbiter.
// Holds the controller state encoding, HD44780 command bytes and init ROM contents.
package lcd_pkg;

    typedef enum logic [2:0] {
        S_POWER_WAIT,
        S_SETUP,
        S_PULSE,
        S_SETTLE,
        S_IDLE
    } state_t;

    localparam logic [7:0] FUNCTION_SET       = 8'h38;
    localparam logic [7:0] ENTRY_MODE         = 8'h06;
    localparam logic [7:0] DISPLAY_CONTROL    = 8'h0C;
    localparam logic [7:0] DISPLAY_CLEAR      = 8'h01;
    localparam logic [7:0] SET_DD_RAM_ADDRESS = 8'h80;

    localparam int unsigned INIT_LEN = 7;
    localparam int unsigned IDX_W    = 3;

    function automatic logic [7:0] init_byte(input logic [IDX_W-1:0] idx);
        logic [7:0] b;
        b = FUNCTION_SET;
        case (idx)
            3'd4:    b = ENTRY_MODE;
            3'd5:    b = DISPLAY_CONTROL;
            3'd6:    b = DISPLAY_CLEAR;
            default: b = FUNCTION_SET;
        endcase
        return b;
    endfunction

    // Clear (0x01) and return-home (0x02/0x03) need the long execution time.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data[7:2] == 6'b0) && (data != 8'h00);
    endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Two-way round-robin grant; only grants while enabled, remembers the last winner.
// last_grant resets to 1 so requester 0 wins the first contested round.
module lcd_rr_arbiter (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic valid0,
    input  logic valid1,
    output logic grant0,
    output logic grant1
);

    logic last_grant;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (enable) begin
            if (valid0 && valid1) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = valid0;
                grant1 = valid1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (grant0) begin
            last_grant <= 1'b0;
        end else if (grant1) begin
            last_grant <= 1'b1;
        end
    end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Owns the HD44780 bus: power-on init sequence, then round-robin byte writes
// from two requesters, each as a full RS/DB setup, E pulse and settle cycle.
module lcd_write_arbiter
    import lcd_pkg::*;
#(
    parameter int unsigned CNT_W            = 20,
    parameter int unsigned FPGA_CONFIG_WAIT = 750000,
    parameter int unsigned INIT_WAIT_1      = 205000,
    parameter int unsigned INIT_WAIT_2      = 5000,
    parameter int unsigned SETUP_WAIT       = 2,
    parameter int unsigned ENABLE_WAIT      = 12,
    parameter int unsigned CMD_WAIT         = 2000,
    parameter int unsigned LONG_WAIT        = 82000
) (
    input  logic       CLOCK_50MHZ,
    input  logic       RESET_N,
    input  logic       REQ0_VALID,
    input  logic       REQ0_RS,
    input  logic [7:0] REQ0_DATA,
    output logic       REQ0_READY,
    input  logic       REQ1_VALID,
    input  logic       REQ1_RS,
    input  logic [7:0] REQ1_DATA,
    output logic       REQ1_READY,
    output logic [7:0] LCD_DATA_BIT,
    output logic       LCD_ENABLE,
    output logic       LCD_REGISTER_SELECT,
    output logic       LCD_READ_WRITE,
    output logic       INIT_DONE,
    output logic       BUSY
);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   stage_wait;
    logic [CNT_W-1:0]   settle_wait;
    logic [CNT_W-1:0]   init_wait;
    logic [CNT_W-1:0]   req_wait;
    logic [IDX_W-1:0]   init_idx;
    logic [7:0]         db;
    logic               rs;
    logic               init_done;
    logic               grant0;
    logic               grant1;
    logic               wait_done;
    logic               load_init;
    logic               load_req;
    logic               finish_init;
    logic               sel_rs;
    logic [7:0]         sel_data;

    lcd_rr_arbiter u_arb (
        .clk    (CLOCK_50MHZ),
        .rst_n  (RESET_N),
        .enable (state == S_IDLE),
        .valid0 (REQ0_VALID),
        .valid1 (REQ1_VALID),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    // init_idx always names the next ROM entry to load, so its settle wait is looked up here.
    always_comb begin
        init_wait = CNT_W'(CMD_WAIT);
        case (init_idx)
            3'd0:    init_wait = CNT_W'(INIT_WAIT_1);
            3'd1:    init_wait = CNT_W'(INIT_WAIT_2);
            3'd6:    init_wait = CNT_W'(LONG_WAIT);
            default: init_wait = CNT_W'(CMD_WAIT);
        endcase
    end

    always_comb begin
        sel_rs   = grant0 ? REQ0_RS   : REQ1_RS;
        sel_data = grant0 ? REQ0_DATA : REQ1_DATA;
        req_wait = is_long_cmd(sel_rs, sel_data) ? CNT_W'(LONG_WAIT) : CNT_W'(CMD_WAIT);
    end

    always_comb begin
        stage_wait = '0;
        case (state)
            S_POWER_WAIT: stage_wait = CNT_W'(FPGA_CONFIG_WAIT);
            S_SETUP:      stage_wait = CNT_W'(SETUP_WAIT);
            S_PULSE:      stage_wait = CNT_W'(ENABLE_WAIT);
            S_SETTLE:     stage_wait = settle_wait;
            default:      stage_wait = '0;
        endcase
        wait_done = (cnt == stage_wait - CNT_W'(1));
    end

    always_comb begin
        state_next  = state;
        load_init   = 1'b0;
        load_req    = 1'b0;
        finish_init = 1'b0;
        case (state)
            S_POWER_WAIT: begin
                if (wait_done) begin
                    state_next = S_SETUP;
                    load_init  = 1'b1;
                end
            end
            S_SETUP: begin
                if (wait_done) state_next = S_PULSE;
            end
            S_PULSE: begin
                if (wait_done) state_next = S_SETTLE;
            end
            S_SETTLE: begin
                if (wait_done) begin
                    if (!init_done && (init_idx != IDX_W'(INIT_LEN))) begin
                        state_next = S_SETUP;
                        load_init  = 1'b1;
                    end else begin
                        state_next  = S_IDLE;
                        finish_init = !init_done;
                    end
                end
            end
            S_IDLE: begin
                if (grant0 || grant1) begin
                    state_next = S_SETUP;
                    load_req   = 1'b1;
                end
            end
            default: state_next = S_POWER_WAIT;
        endcase
    end

    always_ff @(posedge CLOCK_50MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= S_POWER_WAIT;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge CLOCK_50MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt <= '0;
        end else if (state_next != state) begin
            cnt <= '0;
        end else if (state != S_IDLE) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge CLOCK_50MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            db          <= '0;
            rs          <= 1'b0;
            settle_wait <= '0;
            init_idx    <= '0;
            init_done   <= 1'b0;
        end else begin
            if (load_init) begin
                db          <= init_byte(init_idx);
                rs          <= 1'b0;
                settle_wait <= init_wait;
                init_idx    <= init_idx + IDX_W'(1);
            end else if (load_req) begin
                db          <= sel_data;
                rs          <= sel_rs;
                settle_wait <= req_wait;
            end
            if (finish_init) init_done <= 1'b1;
        end
    end

    assign LCD_DATA_BIT        = db;
    assign LCD_ENABLE          = (state == S_PULSE);
    assign LCD_REGISTER_SELECT = rs;
    assign LCD_READ_WRITE      = 1'b0;
    assign INIT_DONE           = init_done;
    assign BUSY                = (state != S_IDLE);
    assign REQ0_READY          = grant0;
    assign REQ1_READY          = grant1;

endmodule
